bellek_asamasi: RTL and testbench

Memory stage of the core pipeline, placed directly downstream of the execute stage and upstream of write-back. Non-memory results from execute are registered straight through. Loads and stores are issued to the data memory port over a valid/ready request and valid response handshake. The pipeline is stalled until the access completes, and load data is aligned and sign/zero-extended before write-back.

---
 rtl/bellek_asamasi_pkg.sv | 49 ++++
 rtl/bellek_asamasi_if.sv | 35 +++
 rtl/bellek_asamasi_yukleme_hizalayici.sv | 25 ++
 rtl/bellek_asamasi.sv | 140 ++++++++++++++
 tb/tb_bellek_asamasi.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bellek_asamasi_pkg.sv
// rtl/bellek_asamasi_pkg.sv - shared size codes, FSM encodings and store-lane helpers for the memory stage
package bellek_asamasi_pkg;

    localparam logic [1:0] BOYUT_B = 2'd0;
    localparam logic [1:0] BOYUT_H = 2'd1;
    localparam logic [1:0] BOYUT_W = 2'd2;

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] YANIT = 2'd2;
    localparam logic [1:0] TAMAM = 2'd3;

    // Access captured when a memory op leaves BOSTA; request fields are driven from this.
    typedef struct packed {
        logic [31:0] adres;
        logic [1:0]  boyut;
        logic        isaretsiz;
        logic        yazma;
        logic [31:0] veri;
        logic [4:0]  rd;
        logic [31:0] pc;
    } erisim_t;

    // Unused size code 3 is treated like a word access throughout.
    function automatic logic hizasiz_mi(input logic [1:0] boyut, input logic [1:0] a);
        case (boyut)
            BOYUT_B: return 1'b0;
            BOYUT_H: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] maske_uret(input logic [1:0] boyut, input logic [1:0] a);
        case (boyut)
            BOYUT_B: return 4'b0001 << a;
            BOYUT_H: return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] veri_cogalt(input logic [1:0] boyut, input logic [31:0] d);
        case (boyut)
            BOYUT_B: return {4{d[7:0]}};
            BOYUT_H: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/bellek_asamasi_if.sv
// rtl/bellek_asamasi_if.sv - data memory request/response port between the memory stage and data memory
interface bellek_asamasi_if;

    logic        veri_istek_gecerli;
    logic        veri_istek_hazir;
    logic [31:0] veri_istek_adres;
    logic        veri_istek_yaz;
    logic [31:0] veri_istek_veri;
    logic [3:0]  veri_istek_maske;
    logic        veri_yanit_gecerli;
    logic [31:0] veri_yanit_veri;

    modport master (
        output veri_istek_gecerli,
        input  veri_istek_hazir,
        output veri_istek_adres,
        output veri_istek_yaz,
        output veri_istek_veri,
        output veri_istek_maske,
        input  veri_yanit_gecerli,
        input  veri_yanit_veri
    );

    modport slave (
        input  veri_istek_gecerli,
        output veri_istek_hazir,
        input  veri_istek_adres,
        input  veri_istek_yaz,
        input  veri_istek_veri,
        input  veri_istek_maske,
        output veri_yanit_gecerli,
        output veri_yanit_veri
    );

endinterface

// File: rtl/bellek_asamasi_yukleme_hizalayici.sv
// rtl/bellek_asamasi_yukleme_hizalayici.sv - extracts a byte/half/word from a load word and sign/zero-extends it
module yukleme_hizalayici
    import bellek_asamasi_pkg::*;
(
    input  logic [31:0] kelime_i,
    input  logic [1:0]  adres_i,
    input  logic [1:0]  boyut_i,
    input  logic        isaretsiz_i,
    output logic [31:0] deger_o
);

    logic [31:0] kaydirilmis;

    always_comb begin
        kaydirilmis = kelime_i >> {adres_i, 3'b000};
        case (boyut_i)
            BOYUT_B: deger_o = isaretsiz_i ? {24'b0, kaydirilmis[7:0]}
                                           : {{24{kaydirilmis[7]}}, kaydirilmis[7:0]};
            BOYUT_H: deger_o = isaretsiz_i ? {16'b0, kaydirilmis[15:0]}
                                           : {{16{kaydirilmis[15]}}, kaydirilmis[15:0]};
            default: deger_o = kaydirilmis;
        endcase
    end

endmodule

// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - memory pipeline stage: passthrough for ALU results, stalling load/store sequencer
module bellek_asamasi
    import bellek_asamasi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        yaz_yazmac_i,
    input  logic [4:0]  rd_adres_i,
    input  logic [31:0] rd_deger_i,
    input  logic [31:0] program_sayaci_artmis_i,
    input  logic        bellek_oku_i,
    input  logic        bellek_yaz_i,
    input  logic [1:0]  bellek_boyut_i,
    input  logic        bellek_isaretsiz_i,
    input  logic [31:0] yaz_deger_i,
    output logic        durdur_o,
    bellek_asamasi_if.master veri_bus,
    output logic        yaz_yazmac_o,
    output logic [4:0]  rd_adres_o,
    output logic [31:0] rd_deger_o,
    output logic [31:0] program_sayaci_artmis_o,
    output logic        hizasiz_hata_o
);

    logic [1:0]  durum_q, durum_d;
    erisim_t     erisim_q, erisim_d;
    logic [31:0] yukleme_q, yukleme_d;
    logic        yaz_yazmac_q, yaz_yazmac_d;
    logic [4:0]  rd_adres_q, rd_adres_d;
    logic [31:0] rd_deger_q, rd_deger_d;
    logic [31:0] pc_q, pc_d;
    logic        hizasiz_q, hizasiz_d;

    logic        bellek_op;
    logic        hizasiz;
    logic [31:0] hizali_deger;

    assign bellek_op = bellek_oku_i | bellek_yaz_i;
    assign hizasiz   = bellek_op & hizasiz_mi(bellek_boyut_i, rd_deger_i[1:0]);

    assign durdur_o = ((durum_q == BOSTA) & bellek_op & ~hizasiz)
                    | (durum_q == ISTEK) | (durum_q == YANIT);

    yukleme_hizalayici u_hizalayici (
        .kelime_i    (veri_bus.veri_yanit_veri),
        .adres_i     (erisim_q.adres[1:0]),
        .boyut_i     (erisim_q.boyut),
        .isaretsiz_i (erisim_q.isaretsiz),
        .deger_o     (hizali_deger)
    );

    // Request fields come only from the captured access, so they stay stable while waiting for hazir.
    assign veri_bus.veri_istek_gecerli = (durum_q == ISTEK);
    assign veri_bus.veri_istek_adres   = {erisim_q.adres[31:2], 2'b00};
    assign veri_bus.veri_istek_yaz     = erisim_q.yazma;
    assign veri_bus.veri_istek_veri    = veri_cogalt(erisim_q.boyut, erisim_q.veri);
    assign veri_bus.veri_istek_maske   = erisim_q.yazma ? maske_uret(erisim_q.boyut, erisim_q.adres[1:0])
                                                        : 4'b0000;

    always_comb begin
        durum_d      = durum_q;
        erisim_d     = erisim_q;
        yukleme_d    = yukleme_q;
        yaz_yazmac_d = 1'b0;
        rd_adres_d   = rd_adres_q;
        rd_deger_d   = rd_deger_q;
        pc_d         = pc_q;
        hizasiz_d    = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (!bellek_op) begin
                    yaz_yazmac_d = yaz_yazmac_i;
                    rd_adres_d   = rd_adres_i;
                    rd_deger_d   = rd_deger_i;
                    pc_d         = program_sayaci_artmis_i;
                end else if (hizasiz) begin
                    hizasiz_d = 1'b1;
                end else begin
                    erisim_d.adres     = rd_deger_i;
                    erisim_d.boyut     = bellek_boyut_i;
                    erisim_d.isaretsiz = bellek_isaretsiz_i;
                    erisim_d.yazma     = bellek_yaz_i;
                    erisim_d.veri      = yaz_deger_i;
                    erisim_d.rd        = rd_adres_i;
                    erisim_d.pc        = program_sayaci_artmis_i;
                    durum_d            = ISTEK;
                end
            end
            ISTEK: begin
                if (veri_bus.veri_istek_hazir) begin
                    durum_d = erisim_q.yazma ? TAMAM : YANIT;
                end
            end
            YANIT: begin
                if (veri_bus.veri_yanit_gecerli) begin
                    yukleme_d = hizali_deger;
                    durum_d   = TAMAM;
                end
            end
            TAMAM: begin
                yaz_yazmac_d = ~erisim_q.yazma & (erisim_q.rd != 5'd0);
                rd_adres_d   = erisim_q.rd;
                rd_deger_d   = yukleme_q;
                pc_d         = erisim_q.pc;
                durum_d      = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q      <= BOSTA;
            erisim_q     <= '0;
            yukleme_q    <= '0;
            yaz_yazmac_q <= 1'b0;
            rd_adres_q   <= '0;
            rd_deger_q   <= '0;
            pc_q         <= '0;
            hizasiz_q    <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            erisim_q     <= erisim_d;
            yukleme_q    <= yukleme_d;
            yaz_yazmac_q <= yaz_yazmac_d;
            rd_adres_q   <= rd_adres_d;
            rd_deger_q   <= rd_deger_d;
            pc_q         <= pc_d;
            hizasiz_q    <= hizasiz_d;
        end
    end

    assign yaz_yazmac_o            = yaz_yazmac_q;
    assign rd_adres_o              = rd_adres_q;
    assign rd_deger_o              = rd_deger_q;
    assign program_sayaci_artmis_o = pc_q;
    assign hizasiz_hata_o          = hizasiz_q;

endmodule

// File: tb/tb_bellek_asamasi.sv
// tb/tb_bellek_asamasi.sv - scoreboard bench for the memory stage against a byte-level memory model
module tb_bellek_asamasi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        yaz_yazmac_i = 1'b0;
    logic [4:0]  rd_adres_i = '0;
    logic [31:0] rd_deger_i = '0;
    logic [31:0] pc_i = '0;
    logic        oku_i = 1'b0;
    logic        yaz_i = 1'b0;
    logic [1:0]  boyut_i = '0;
    logic        isaretsiz_i = 1'b0;
    logic [31:0] yaz_deger_i = '0;
    logic        durdur_o;
    logic        yaz_yazmac_o;
    logic [4:0]  rd_adres_o;
    logic [31:0] rd_deger_o;
    logic [31:0] pc_o;
    logic        hizasiz_hata_o;

    bellek_asamasi_if bus();

    bellek_asamasi dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .yaz_yazmac_i            (yaz_yazmac_i),
        .rd_adres_i              (rd_adres_i),
        .rd_deger_i              (rd_deger_i),
        .program_sayaci_artmis_i (pc_i),
        .bellek_oku_i            (oku_i),
        .bellek_yaz_i            (yaz_i),
        .bellek_boyut_i          (boyut_i),
        .bellek_isaretsiz_i      (isaretsiz_i),
        .yaz_deger_i             (yaz_deger_i),
        .durdur_o                (durdur_o),
        .veri_bus                (bus),
        .yaz_yazmac_o            (yaz_yazmac_o),
        .rd_adres_o              (rd_adres_o),
        .rd_deger_o              (rd_deger_o),
        .program_sayaci_artmis_o (pc_o),
        .hizasiz_hata_o          (hizasiz_hata_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          hiz;
        logic [4:0]  rd;
        logic [31:0] deger;
        logic [31:0] pc;
    } wb_t;

    typedef struct {
        logic [31:0] adres;
        bit          yaz;
        logic [31:0] veri;
        logic [3:0]  maske;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];

    logic [7:0]  ref_mem [int];
    logic [31:0] wmem [int];

    int          forced_late = -1;
    int          forced_resp = -1;
    bit          pending = 1'b0;
    int          resp_delay = 0;
    logic [31:0] resp_word = '0;
    int          wait_cnt = 0;
    int          cur_late = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_b(input int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
    endfunction

    function automatic logic [31:0] mem_word(input int wa);
        if (wmem.exists(wa)) return wmem[wa];
        return {init_b(wa + 3), init_b(wa + 2), init_b(wa + 1), init_b(wa)};
    endfunction

    task automatic poke(input int wa, input logic [31:0] w);
        wmem[wa] = w;
        for (int i = 0; i < 4; i++) ref_mem[wa + i] = w[8*i +: 8];
    endtask

    // kind: 0 ALU result, 1 load, 2 store. Entered and left 1 time unit after a rising edge.
    task automatic issue(input int kind, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                         input logic [31:0] sd, input logic [4:0] rd, input bit yaz, input int exp_stall);
        logic [31:0] pc, v, dv;
        logic [3:0]  m;
        int          n, ai, stall;
        bit          done;
        wb_t         w;
        req_t        r;
        pc = $urandom;
        yaz_yazmac_i = yaz; rd_adres_i = rd; rd_deger_i = a; pc_i = pc;
        oku_i = (kind == 1); yaz_i = (kind == 2); boyut_i = sz; isaretsiz_i = uns; yaz_deger_i = sd;
        n  = 1 << sz;
        ai = int'(a);
        if (kind == 0) begin
            if (yaz) begin w.hiz = 0; w.rd = rd; w.deger = a; w.pc = pc; wb_q.push_back(w); end
        end else if ((ai % n) != 0) begin
            w.hiz = 1; w.rd = 0; w.deger = 0; w.pc = 0; wb_q.push_back(w);
        end else begin
            m = '0; dv = '0;
            for (int i = 0; i < n; i++) m[(ai % 4) + i] = 1'b1;
            for (int j = 0; j < 4; j++) dv[8*j +: 8] = sd[8*(j % n) +: 8];
            r.adres = a & 32'hFFFF_FFFC; r.yaz = (kind == 2);
            r.maske = (kind == 2) ? m : 4'b0000; r.veri = dv;
            req_q.push_back(r);
            if (kind == 2) begin
                for (int i = 0; i < n; i++) ref_mem[ai + i] = sd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_byte(ai + i)) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                if (rd != 5'd0) begin w.hiz = 0; w.rd = rd; w.deger = v; w.pc = pc; wb_q.push_back(w); end
            end
        end
        stall = 0; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (!durdur_o) done = 1;
            else begin stall++; @(posedge clk); end
        end
        if (!done) begin
            fails++; tests++;
            $display("FAIL stall_timeout: durdur_o still high after 60 cycles, expected release");
        end
        @(posedge clk); #1;
        if (exp_stall >= 0) check("stall_cycles", stall, exp_stall);
    endtask

    // Write-back monitor: every visible write or misalignment pulse retires one expected entry.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (yaz_yazmac_o || hizasiz_hata_o)) begin
                if (wb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wb_unexpected: got yaz=%0d hiz=%0d rd=%0d deger=0x%08h, expected no output",
                             yaz_yazmac_o, hizasiz_hata_o, rd_adres_o, rd_deger_o);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_hiz", hizasiz_hata_o, e.hiz);
                    if (e.hiz) check("hiz_yaz", yaz_yazmac_o, 0);
                    else begin
                        check("wb_rd", rd_adres_o, e.rd);
                        check("wb_deger", rd_deger_o, e.deger);
                        check("wb_pc", pc_o, e.pc);
                    end
                end
            end
        end
    end

    // Data memory model: randomly delayed hazir, delayed load responses, stray response noise.
    initial begin
        req_t e;
        int   wa;
        logic [31:0] w;
        bus.veri_istek_hazir = 1'b0;
        bus.veri_yanit_gecerli = 1'b0;
        bus.veri_yanit_veri = '0;
        forever begin
            @(posedge clk); #1;
            bus.veri_yanit_gecerli = 1'b0;
            if (pending) begin
                if (resp_delay == 0) begin
                    bus.veri_yanit_gecerli = 1'b1; bus.veri_yanit_veri = resp_word; pending = 1'b0;
                end else resp_delay--;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.veri_yanit_gecerli = 1'b1; bus.veri_yanit_veri = $urandom;
            end
            if (bus.veri_istek_gecerli) begin
                if (wait_cnt == 0) cur_late = (forced_late >= 0) ? forced_late : int'($urandom_range(0, 2));
                bus.veri_istek_hazir = (wait_cnt >= cur_late);
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                bus.veri_istek_hazir = $urandom_range(0, 1) == 1;
            end
            @(negedge clk);
            if (bus.veri_istek_gecerli && bus.veri_istek_hazir) begin
                wait_cnt = 0;
                wa = int'(bus.veri_istek_adres);
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL req_unexpected: got request adres=0x%08h, expected none", bus.veri_istek_adres);
                end else begin
                    e = req_q.pop_front();
                    check("req_adres", bus.veri_istek_adres, e.adres);
                    check("req_yaz", bus.veri_istek_yaz, e.yaz);
                    check("req_maske", bus.veri_istek_maske, e.maske);
                    if (e.yaz) check("req_veri", bus.veri_istek_veri, e.veri);
                end
                if (bus.veri_istek_yaz) begin
                    w = mem_word(wa);
                    for (int j = 0; j < 4; j++)
                        if (bus.veri_istek_maske[j]) w[8*j +: 8] = bus.veri_istek_veri[8*j +: 8];
                    wmem[wa] = w;
                end else begin
                    pending    = 1'b1;
                    resp_delay = (forced_resp >= 0) ? forced_resp : int'($urandom_range(0, 2));
                    resp_word  = mem_word(wa);
                end
            end
        end
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        req_t r;
        repeat (3) @(posedge clk);
        #1;
        check("rst_yaz", yaz_yazmac_o, 0);
        check("rst_rd", rd_adres_o, 0);
        check("rst_deger", rd_deger_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_hiz", hizasiz_hata_o, 0);
        check("rst_gecerli", bus.veri_istek_gecerli, 0);
        check("rst_durdur", durdur_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 32'h1234_5678, 2'd0, 0, 0, 5'd5, 1, 0);
        forced_late = 2; forced_resp = 0;
        issue(2, 32'h0000_1003, 2'd0, 0, 32'h0000_00AB, 5'd0, 0, 4);
        forced_late = 0;
        poke(32'h2000, 32'h0080_0000);
        issue(1, 32'h0000_2002, 2'd0, 0, 0, 5'd7, 1, 3);
        issue(1, 32'h0000_2002, 2'd0, 1, 0, 5'd8, 1, 3);
        poke(32'h3000, 32'h8001_0000);
        issue(1, 32'h0000_3002, 2'd1, 0, 0, 5'd9, 1, 3);
        issue(1, 32'h0000_4001, 2'd2, 0, 0, 5'd10, 1, 0);
        issue(2, 32'h0000_4002, 2'd2, 0, 32'hDEAD_BEEF, 5'd0, 0, 0);

        // Reset while a load waits in YANIT; the late response must not reach write-back.
        forced_late = 0; forced_resp = 6;
        yaz_yazmac_i = 1; rd_adres_i = 5'd11; rd_deger_i = 32'h5000; pc_i = 32'h44;
        oku_i = 1; yaz_i = 0; boyut_i = 2'd2; isaretsiz_i = 0;
        r.adres = 32'h5000; r.yaz = 0; r.maske = 4'b0000; r.veri = '0;
        req_q.push_back(r);
        repeat (3) @(negedge clk);
        yaz_yazmac_i = 0; rd_adres_i = 0; rd_deger_i = 0; pc_i = 0; oku_i = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gecerli", bus.veri_istek_gecerli, 0);
        check("mid_rst_yaz", yaz_yazmac_o, 0);
        check("mid_rst_deger", rd_deger_o, 0);
        check("mid_rst_pc", pc_o, 0);
        check("mid_rst_durdur", durdur_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("late_resp_yaz", yaz_yazmac_o, 0);
        check("late_resp_deger", rd_deger_o, 0);
        check("late_resp_pending", pending, 0);

        forced_late = -1; forced_resp = -1;
        for (int t = 0; t < 300; t++) begin
            int kind;
            logic [31:0] a;
            logic [1:0]  sz;
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            a    = (kind == 0) ? $urandom : 32'(32'h100 + $urandom_range(0, 63));
            issue(kind, a, sz, $urandom_range(0, 1) == 1, $urandom, 5'($urandom),
                  (kind == 1) || ($urandom_range(0, 3) != 0), (kind == 0) ? 0 : -1);
        end

        yaz_yazmac_i = 0; oku_i = 0; yaz_i = 0;
        repeat (5) @(posedge clk);
        #1;
        check("wb_queue_empty", wb_q.size(), 0);
        check("req_queue_empty", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
